// File: rtl/issue_scoreboard.sv
// Issue controller holding one decoded instruction. A 32-bit pending scoreboard
// and an in-flight counter block RAW/WAW hazards, and a branch flush squashes the slot.
module issue_scoreboard #(
  parameter int MAX_INFLIGHT = 4,
  parameter int FLUSH_CYC    = 1,
  parameter bit WB_BYPASS    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid_i,
  output logic        dec_ready_o,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        use_rs1_i,
  input  logic        use_rs2_i,
  input  logic        rd_we_i,
  output logic        issue_valid_o,
  input  logic        ex_ready_i,
  output logic [4:0]  issue_rd_addr_o,
  output logic        issue_rd_we_o,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_addr_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [3:0]  in_flight_o,
  output logic [31:0] pending_o,
  output logic        err_o
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [2:0]  bub_q, bub_d;
  logic        hold_v_q, hold_v_d;
  logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic        use1_q, use1_d, use2_q, use2_d, we_q, we_d;
  logic [31:0] pend_q, pend_d;
  logic [3:0]  inflight_q, inflight_d;
  logic        err_q, err_d;

  logic [31:0] wb_mask, pend_eff, set_mask;
  logic        hazard, eligible, issue, accept, wb_ok, do_set;

  // A retiring writeback may clear a hazard in the same cycle it lands.
  assign wb_mask  = wb_valid_i ? (32'd1 << wb_addr_i) : 32'd0;
  assign pend_eff = WB_BYPASS ? (pend_q & ~wb_mask) : pend_q;
  assign hazard   = (use1_q && pend_eff[rs1_q]) || (use2_q && pend_eff[rs2_q]) ||
                    (we_q && pend_eff[rd_q]);
  assign eligible = !hazard && ((inflight_q < 4'(MAX_INFLIGHT)) || !we_q);

  assign issue_valid_o   = hold_v_q && eligible && (state_q != FLUSH) && !flush_i;
  assign issue           = issue_valid_o && ex_ready_i;
  assign dec_ready_o     = (state_q != FLUSH) && !flush_i && (!hold_v_q || issue);
  assign accept          = dec_valid_i && dec_ready_o;
  assign issue_rd_addr_o = rd_q;
  assign issue_rd_we_o   = we_q;
  assign stall_o         = (state_q == STALL);
  assign in_flight_o     = inflight_q;
  assign pending_o       = pend_q;
  assign err_o           = err_q;

  // Writebacks with nothing outstanding only raise the sticky error.
  assign wb_ok    = wb_valid_i && (inflight_q != 4'd0);
  assign do_set   = issue && we_q && (rd_q != 5'd0);
  assign set_mask = do_set ? (32'd1 << rd_q) : 32'd0;

  always_comb begin
    pend_d     = (pend_q & ~(wb_ok ? wb_mask : 32'd0)) | set_mask;
    inflight_d = inflight_q + 4'(do_set) - 4'(wb_ok);
    err_d      = err_q | (wb_valid_i && (inflight_q == 4'd0));
  end

  always_comb begin
    hold_v_d = hold_v_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    use1_d   = use1_q;
    use2_d   = use2_q;
    we_d     = we_q;
    if (flush_i) begin
      hold_v_d = 1'b0;
    end else if (accept) begin
      hold_v_d = 1'b1;
      rs1_d    = rs1_addr_i;
      rs2_d    = rs2_addr_i;
      rd_d     = rd_addr_i;
      use1_d   = use_rs1_i;
      use2_d   = use_rs2_i;
      we_d     = rd_we_i;
    end else if (issue) begin
      hold_v_d = 1'b0;
    end
  end

  // The bubble counter holds the FLUSH cycles still to run after this one.
  always_comb begin
    state_d = state_q;
    bub_d   = bub_q;
    if (flush_i) begin
      state_d = FLUSH;
      bub_d   = 3'(FLUSH_CYC - 1);
    end else begin
      case (state_q)
        RUN:     if (hold_v_q && !eligible) state_d = STALL;
        STALL:   if (!hold_v_q || eligible) state_d = RUN;
        FLUSH:   if (bub_q == 3'd0) state_d = RUN;
                 else bub_d = bub_q - 3'd1;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      bub_q      <= 3'd0;
      hold_v_q   <= 1'b0;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      rd_q       <= 5'd0;
      use1_q     <= 1'b0;
      use2_q     <= 1'b0;
      we_q       <= 1'b0;
      pend_q     <= 32'd0;
      inflight_q <= 4'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bub_q      <= bub_d;
      hold_v_q   <= hold_v_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      use1_q     <= use1_d;
      use2_q     <= use2_d;
      we_q       <= we_d;
      pend_q     <= pend_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: a per-register outstanding-write model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_issue_scoreboard;
  localparam int MaxInflight = 4;
  localparam int FlushCyc    = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dec_valid, dec_ready, use_rs1, use_rs2, rd_we;
  logic [4:0]  rs1, rs2, rd, issue_rd_addr, wb_addr;
  logic        issue_valid, ex_ready, issue_rd_we, wb_valid, flush, stall, err;
  logic [3:0]  in_flight;
  logic [31:0] pending;

  int checks = 0;
  int failures = 0;

  issue_scoreboard #(.MAX_INFLIGHT(MaxInflight), .FLUSH_CYC(FlushCyc), .WB_BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid_i(dec_valid), .dec_ready_o(dec_ready),
    .rs1_addr_i(rs1), .rs2_addr_i(rs2), .rd_addr_i(rd),
    .use_rs1_i(use_rs1), .use_rs2_i(use_rs2), .rd_we_i(rd_we),
    .issue_valid_o(issue_valid), .ex_ready_i(ex_ready),
    .issue_rd_addr_o(issue_rd_addr), .issue_rd_we_o(issue_rd_we),
    .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .flush_i(flush),
    .stall_o(stall), .in_flight_o(in_flight), .pending_o(pending), .err_o(err)
  );

  always #5 clk = ~clk;

  // Model: which registers have a write outstanding, the held instruction,
  // remaining flush bubbles, and whether the controller reports a stall.
  bit         mPend [32];
  int         mCount, mBubbles;
  bit         mHeldV, mU1, mU2, mWe, mStall, mErr;
  logic [4:0] mRs1, mRs2, mRd;

  function automatic bit srcBusy(input logic [4:0] r);
    return mPend[r] && !(wb_valid && wb_addr == r);
  endfunction

  function automatic bit expEligible();
    bit haz;
    haz = (mU1 && srcBusy(mRs1)) || (mU2 && srcBusy(mRs2)) || (mWe && srcBusy(mRd));
    return !haz && (mCount < MaxInflight || !mWe);
  endfunction

  function automatic bit expIssueValid();
    return mHeldV && expEligible() && mBubbles == 0 && !flush;
  endfunction

  function automatic bit expDecReady();
    return mBubbles == 0 && !flush && (!mHeldV || (expIssueValid() && ex_ready));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    bit iss, acc, elig;
    int cnt;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mPend[i] <= 1'b0;
      mCount <= 0; mBubbles <= 0; mHeldV <= 1'b0; mStall <= 1'b0; mErr <= 1'b0;
    end else begin
      iss  = expIssueValid() && ex_ready;
      acc  = dec_valid && expDecReady();
      elig = expEligible();
      cnt  = mCount;
      if (wb_valid) begin
        if (mCount == 0) mErr <= 1'b1;
        else begin
          mPend[wb_addr] <= 1'b0;
          cnt--;
        end
      end
      if (iss && mWe && mRd != 5'd0) begin
        mPend[mRd] <= 1'b1;
        cnt++;
      end
      mCount <= cnt;
      if (flush) mHeldV <= 1'b0;
      else if (acc) begin
        mHeldV <= 1'b1; mRs1 <= rs1; mRs2 <= rs2; mRd <= rd;
        mU1 <= use_rs1; mU2 <= use_rs2; mWe <= rd_we;
      end else if (iss) mHeldV <= 1'b0;
      if (flush) begin
        mBubbles <= FlushCyc; mStall <= 1'b0;
      end else if (mBubbles > 0) begin
        mBubbles <= mBubbles - 1; mStall <= 1'b0;
      end else mStall <= mHeldV && !elig;
    end
  end

  always @(negedge clk) begin
    logic [31:0] ep;
    for (int i = 0; i < 32; i++) ep[i] = mPend[i];
    checkOutput("issue_valid", 32'(issue_valid), 32'(expIssueValid()));
    checkOutput("dec_ready", 32'(dec_ready), 32'(expDecReady()));
    checkOutput("stall", 32'(stall), 32'(mStall));
    checkOutput("in_flight", 32'(in_flight), 32'(mCount));
    checkOutput("pending", pending, ep);
    checkOutput("err", 32'(err), 32'(mErr));
    if (expIssueValid()) begin
      checkOutput("issue_rd_addr", 32'(issue_rd_addr), 32'(mRd));
      checkOutput("issue_rd_we", 32'(issue_rd_we), 32'(mWe));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit v, input logic [4:0] a1, input logic [4:0] a2,
                               input logic [4:0] d, input bit u1, input bit u2, input bit we);
    dec_valid = v; rs1 = a1; rs2 = a2; rd = d; use_rs1 = u1; use_rs2 = u2; rd_we = we;
  endtask

  task automatic writeback(input bit v, input logic [4:0] a);
    wb_valid = v; wb_addr = a;
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    writeback(0, 0);
    flush = 1'b0; ex_ready = 1'b1;
    repeat (2) step();
    settle();
    checkOutput("rst_dec_ready", 32'(dec_ready), 32'd1);
    checkOutput("rst_issue_valid", 32'(issue_valid), 32'd0);
    checkOutput("rst_pending", pending, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Back-to-back independent writers x1, x2.
    applyStimulus(1, 3, 4, 1, 1, 1, 1); step();
    applyStimulus(1, 3, 4, 2, 1, 1, 1);
    settle(); checkOutput("b2b_first_issue", 32'(issue_valid), 32'd1); step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    settle(); checkOutput("b2b_second_rd", 32'(issue_rd_addr), 32'd2); step();
    writeback(1, 1);
    settle(); checkOutput("b2b_pending", pending, 32'h6);
    checkOutput("b2b_inflight", 32'(in_flight), 32'd2); step();
    writeback(1, 2); step();
    writeback(0, 0); step();

    // RAW on x5 resolved by a same-cycle writeback.
    applyStimulus(1, 0, 0, 5, 0, 0, 1); step();
    applyStimulus(1, 5, 0, 0, 1, 0, 0); step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    settle(); checkOutput("raw_blocked", 32'(issue_valid), 32'd0);
    checkOutput("raw_dec_ready", 32'(dec_ready), 32'd0); step();
    writeback(1, 5);
    settle(); checkOutput("raw_stall", 32'(stall), 32'd1);
    checkOutput("raw_bypass_issue", 32'(issue_valid), 32'd1); step();
    writeback(0, 0);
    settle(); checkOutput("raw_unstall", 32'(stall), 32'd0); step();

    // In-flight limit: four writers, then a store, then a fifth writer.
    for (int r = 1; r <= 4; r++) begin
      applyStimulus(1, 0, 0, 5'(r), 0, 0, 1); step();
    end
    applyStimulus(1, 9, 0, 0, 1, 0, 0); step();
    applyStimulus(1, 0, 0, 8, 0, 0, 1);
    settle(); checkOutput("lim_store_issues", 32'(issue_valid), 32'd1); step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    settle(); checkOutput("lim_fifth_blocked", 32'(issue_valid), 32'd0); step();
    writeback(1, 1);
    settle(); checkOutput("lim_still_full", 32'(issue_valid), 32'd0); step();
    writeback(0, 0);
    settle(); checkOutput("lim_fifth_issues", 32'(issue_valid), 32'd1); step();
    settle(); checkOutput("lim_pending", pending, 32'h11C);
    checkOutput("lim_inflight", 32'(in_flight), 32'd4);
    for (int r = 2; r <= 4; r++) begin
      writeback(1, 5'(r)); step();
    end
    writeback(1, 8); step();
    writeback(0, 0); step();

    // Flush of a stalled reader; decoder input ignored during flush.
    applyStimulus(1, 0, 0, 10, 0, 0, 1); step();
    applyStimulus(1, 10, 0, 0, 1, 0, 0); step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0); step(); step();
    flush = 1'b1;
    applyStimulus(1, 0, 0, 11, 0, 0, 1);
    settle(); checkOutput("flush_no_issue", 32'(issue_valid), 32'd0);
    checkOutput("flush_dec_ready", 32'(dec_ready), 32'd0); step();
    flush = 1'b0;
    settle(); checkOutput("bubble_dec_ready", 32'(dec_ready), 32'd0);
    checkOutput("bubble_pending", pending, 32'h400); step();
    settle(); checkOutput("post_flush_ready", 32'(dec_ready), 32'd1);
    checkOutput("post_flush_empty", 32'(issue_valid), 32'd0); step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0); step();
    writeback(1, 10); step();
    writeback(1, 11); step();
    writeback(0, 0); step();

    // WAW on x7 resolved by the prior writer's writeback; then an x0 writer.
    applyStimulus(1, 0, 0, 7, 0, 0, 1); step();
    applyStimulus(1, 0, 0, 7, 0, 0, 1); step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    settle(); checkOutput("waw_blocked", 32'(issue_valid), 32'd0); step();
    writeback(1, 7);
    settle(); checkOutput("waw_bypass_issue", 32'(issue_valid), 32'd1); step();
    writeback(0, 0);
    settle(); checkOutput("same_cyc_pending", pending, 32'h80);
    checkOutput("same_cyc_inflight", 32'(in_flight), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 1); step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0); step();
    settle(); checkOutput("x0_pending", pending, 32'h80);
    checkOutput("x0_inflight", 32'(in_flight), 32'd1);
    writeback(1, 7); step();
    writeback(0, 0); step();

    // Reset in the middle of a stall, then a spurious writeback.
    applyStimulus(1, 0, 0, 3, 0, 0, 1); step();
    applyStimulus(1, 0, 3, 0, 0, 1, 0); step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0); step();
    rst_n = 1'b0;
    settle(); checkOutput("midrst_stall", 32'(stall), 32'd0);
    checkOutput("midrst_dec_ready", 32'(dec_ready), 32'd1);
    checkOutput("midrst_pending", pending, 32'd0);
    checkOutput("midrst_inflight", 32'(in_flight), 32'd0); step();
    rst_n = 1'b1; step();
    writeback(1, 9);
    settle(); checkOutput("spur_err_before", 32'(err), 32'd0); step();
    writeback(0, 0);
    settle(); checkOutput("spur_err_set", 32'(err), 32'd1);
    checkOutput("spur_inflight", 32'(in_flight), 32'd0); step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
